hazard_scoreboard: RTL and testbench

- Parametrised successor to the pipeline hazard unit.
- Tracks up to NUM_PENDING in-flight long-latency ops (loads, mul/div) in a tagged scoreboard.
- Stalls PC/IF and bubbles ID→EX on RAW hazards, WAW hazards and scoreboard-full conditions. Branch flush takes priority.
- Sits beside the ID stage. Issue comes from ID, completion from the WB port of the variable-latency units.

---
 rtl/hazard_pkg.sv | 38 +++
 rtl/hazard_scoreboard_if.sv | 56 +++++
 rtl/sb_free_finder.sv | 25 ++
 rtl/hazard_scoreboard.sv | 196 +++++++++++++++++++
 tb/tb_hazard_scoreboard.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard scoreboard.
// Register address width, scoreboard entry layout, long-op opcodes.
package hazard_pkg;

  localparam int REG_ADDR_W = 5;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  typedef struct packed {
    logic      valid;
    reg_addr_t rd;
  } sb_entry_t;

  // Major opcodes (inst[6:2]) of ops that finish
  // in a variable-latency unit.
  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_MULDIV = 5'b01100;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  // Decoder helper: does this instruction take the
  // long-latency writeback path?
  function automatic logic is_long_op(
    input logic [4:0] opc,
    input logic [6:0] funct7
  );
    logic r;
    r = 1'b0;
    if (opc == OP_LOAD) begin
      r = 1'b1;
    end else if (opc == OP_MULDIV &&
                 funct7 == FUNCT7_MULDIV) begin
      r = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// ID-stage / completion / control bundle of the hazard scoreboard.
// master = pipeline side, slave = scoreboard side.
interface hazard_scoreboard_if
  import hazard_pkg::*;
#(
  parameter int TAG_W = 2
) ();

  // ID-stage instruction
  reg_addr_t        rs1_addr_ID;
  reg_addr_t        rs2_addr_ID;
  logic             rs1_used_ID;
  logic             rs2_used_ID;
  reg_addr_t        rd_addr_ID;
  logic             long_op_ID;
  logic             flush_br;

  // completion from the WB port
  logic             cmpl_valid;
  logic [TAG_W-1:0] cmpl_tag;

  // pipeline control back to IF/ID
  logic [TAG_W-1:0] alloc_tag;
  logic             issue;
  logic             stall_pc;
  logic             stall_IF;
  logic             flush_IF;
  logic             flush_ID;
  logic             sb_full;
  logic             sb_err;

  modport master (
    output rs1_addr_ID, rs2_addr_ID,
    output rs1_used_ID, rs2_used_ID,
    output rd_addr_ID, long_op_ID,
    output flush_br,
    output cmpl_valid, cmpl_tag,
    input  alloc_tag, issue,
    input  stall_pc, stall_IF,
    input  flush_IF, flush_ID,
    input  sb_full, sb_err
  );

  modport slave (
    input  rs1_addr_ID, rs2_addr_ID,
    input  rs1_used_ID, rs2_used_ID,
    input  rd_addr_ID, long_op_ID,
    input  flush_br,
    input  cmpl_valid, cmpl_tag,
    output alloc_tag, issue,
    output stall_pc, stall_IF,
    output flush_IF, flush_ID,
    output sb_full, sb_err
  );

endinterface

// File: rtl/sb_free_finder.sv
// Lowest-index free entry priority encoder.
// Ports: free_i (1=entry free), idx_o (lowest free), none_o (no free).
module sb_free_finder #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  free_i,
  output logic [IW-1:0] idx_o,
  output logic          none_o
);

  // Scan high to low so the lowest free index
  // is the last one written.
  always_comb begin
    idx_o  = '0;
    none_o = 1'b1;
    for (int i = N - 1; i >= 0; i--) begin
      if (free_i[i]) begin
        idx_o  = IW'(i);
        none_o = 1'b0;
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Tagged scoreboard for in-flight long ops; RAW/WAW/full hazard control.
// Ports: clk, rst_n, sb (slave bundle); HAZARD_SB_PERF_EN adds counters.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NUM_PENDING = 4,
  parameter int TAG_W       = $clog2(NUM_PENDING),
  parameter bit WB_BYPASS   = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  hazard_scoreboard_if.slave  sb
`ifdef HAZARD_SB_PERF_EN
  ,
  output logic [31:0]         stall_cnt,
  output logic [31:0]         raw_cnt,
  output logic [31:0]         full_cnt
`endif
);

  localparam int NP = NUM_PENDING;

  sb_entry_t [NP-1:0] ent_q, ent_d;
  logic               err_q, err_d;

  logic [NP-1:0] vld;
  logic [NP-1:0] cmpl_dec;
  logic [NP-1:0] live;
  logic [NP-1:0] rs1_m;
  logic [NP-1:0] rs2_m;
  logic [NP-1:0] rd_m;

  logic             rs1_hit;
  logic             rs2_hit;
  logic             raw_hz;
  logic             waw_hz;
  logic             full_hz;
  logic             hz;
  logic             long_ok;
  logic             full;
  logic [TAG_W-1:0] free_idx;
  logic             cmpl_ok;

  logic issue;
  logic stall;
  logic fl_if;
  logic fl_id;

  // Per-entry match vectors. An entry completing this
  // cycle is not live when the WB value is bypassed.
  always_comb begin
    vld      = '0;
    cmpl_dec = '0;
    live     = '0;
    rs1_m    = '0;
    rs2_m    = '0;
    rd_m     = '0;
    for (int i = 0; i < NP; i++) begin
      vld[i]      = ent_q[i].valid;
      cmpl_dec[i] = sb.cmpl_valid &&
                    (sb.cmpl_tag == TAG_W'(i));
      live[i]     = vld[i] &&
                    !(WB_BYPASS && cmpl_dec[i]);
      rs1_m[i]    = live[i] &&
                    (ent_q[i].rd == sb.rs1_addr_ID);
      rs2_m[i]    = live[i] &&
                    (ent_q[i].rd == sb.rs2_addr_ID);
      rd_m[i]     = live[i] &&
                    (ent_q[i].rd == sb.rd_addr_ID);
    end
  end

  sb_free_finder #(
    .N  (NP),
    .IW (TAG_W)
  ) u_free (
    .free_i (~vld),
    .idx_o  (free_idx),
    .none_o (full)
  );

  assign long_ok = sb.long_op_ID &&
                   (sb.rd_addr_ID != '0);

  assign rs1_hit = sb.rs1_used_ID &&
                   (sb.rs1_addr_ID != '0) &&
                   (|rs1_m);
  assign rs2_hit = sb.rs2_used_ID &&
                   (sb.rs2_addr_ID != '0) &&
                   (|rs2_m);

  assign raw_hz  = rs1_hit || rs2_hit;
  assign waw_hz  = long_ok && (|rd_m);
  assign full_hz = long_ok && full;
  assign hz      = raw_hz || waw_hz || full_hz;

  // Branch flush overrides any hazard: the ID
  // instruction is wrong-path and must not allocate.
  always_comb begin
    issue = 1'b0;
    stall = 1'b0;
    fl_if = 1'b0;
    fl_id = 1'b0;
    if (sb.flush_br) begin
      fl_if = 1'b1;
      fl_id = 1'b1;
    end else if (hz) begin
      stall = 1'b1;
      fl_id = 1'b1;
    end else begin
      issue = long_ok;
    end
  end

  assign sb.issue     = issue;
  assign sb.alloc_tag = free_idx;
  assign sb.stall_pc  = stall;
  assign sb.stall_IF  = stall;
  assign sb.flush_IF  = fl_if;
  assign sb.flush_ID  = fl_id;
  assign sb.sb_full   = full;
  assign sb.sb_err    = err_q;

  assign cmpl_ok = |(cmpl_dec & vld);

  // Clear before set: the allocated entry is free in the
  // current state, so it never collides with a valid
  // completion; a completion on it is an error anyway.
  always_comb begin
    ent_d = ent_q;
    err_d = err_q;
    for (int i = 0; i < NP; i++) begin
      if (cmpl_dec[i]) begin
        ent_d[i].valid = 1'b0;
      end
      if (issue && (free_idx == TAG_W'(i))) begin
        ent_d[i].valid = 1'b1;
        ent_d[i].rd    = sb.rd_addr_ID;
      end
    end
    if (sb.cmpl_valid && !cmpl_ok) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_q <= '0;
      err_q <= 1'b0;
    end else begin
      ent_q <= ent_d;
      err_q <= err_d;
    end
  end

`ifdef HAZARD_SB_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] raw_cnt_q, raw_cnt_d;
  logic [31:0] full_cnt_q, full_cnt_d;

  // Saturating event counters.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    raw_cnt_d   = raw_cnt_q;
    full_cnt_d  = full_cnt_q;
    if (!sb.flush_br) begin
      if (hz && !(&stall_cnt_q)) begin
        stall_cnt_d = stall_cnt_q + 32'd1;
      end
      if (raw_hz && !(&raw_cnt_q)) begin
        raw_cnt_d = raw_cnt_q + 32'd1;
      end
      if (full_hz && !(&full_cnt_q)) begin
        full_cnt_d = full_cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      raw_cnt_q   <= '0;
      full_cnt_q  <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      raw_cnt_q   <= raw_cnt_d;
      full_cnt_q  <= full_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign raw_cnt   = raw_cnt_q;
  assign full_cnt  = full_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard, WB_BYPASS=1 and WB_BYPASS=0.
// Driver pushes model expectations; negedge monitor pops and compares.
module tb_hazard_scoreboard;
  import hazard_pkg::*;

  localparam int NP = 4;
  localparam int TW = 2;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  hazard_scoreboard_if #(.TAG_W(TW)) b0 ();
  hazard_scoreboard_if #(.TAG_W(TW)) b1 ();

  hazard_scoreboard #(
    .NUM_PENDING (NP),
    .TAG_W       (TW),
    .WB_BYPASS   (1'b0)
  ) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .sb    (b0)
  );

  hazard_scoreboard #(
    .NUM_PENDING (NP),
    .TAG_W       (TW),
    .WB_BYPASS   (1'b1)
  ) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .sb    (b1)
  );

  typedef struct packed {
    logic          issue;
    logic [TW-1:0] tag;
    logic          spc;
    logic          sif;
    logic          fif;
    logic          fid;
    logic          full;
    logic          err;
  } out_t;

  typedef struct {
    out_t o[2];
    bit   tagchk[2];
    int   phase;
  } exp_t;

  exp_t q[$];

  // Model: pending destination per tag, -1 = free.
  int m_rd[2][NP];
  bit m_err[2];

  int checks   = 0;
  int failures = 0;
  int stall_ph[2];

  function automatic bit pend(int k, int r, bit byp,
                              bit cv, int ct);
    for (int i = 0; i < NP; i++) begin
      if (m_rd[k][i] == r && !(byp && cv && ct == i))
        return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic drive(bit rn, int rs1, bit u1,
                       int rs2, bit u2, int rd,
                       bit lo, bit fb, bit cv,
                       int ct, int ph);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n          = rn;
    b0.rs1_addr_ID = 5'(rs1);
    b1.rs1_addr_ID = 5'(rs1);
    b0.rs2_addr_ID = 5'(rs2);
    b1.rs2_addr_ID = 5'(rs2);
    b0.rs1_used_ID = u1;
    b1.rs1_used_ID = u1;
    b0.rs2_used_ID = u2;
    b1.rs2_used_ID = u2;
    b0.rd_addr_ID  = 5'(rd);
    b1.rd_addr_ID  = 5'(rd);
    b0.long_op_ID  = lo;
    b1.long_op_ID  = lo;
    b0.flush_br    = fb;
    b1.flush_br    = fb;
    b0.cmpl_valid  = cv;
    b1.cmpl_valid  = cv;
    b0.cmpl_tag    = TW'(ct);
    b1.cmpl_tag    = TW'(ct);
    e.phase = ph;
    for (int k = 0; k < 2; k++) begin
      bit   byp;
      bit   raw, waw, st, hz, full;
      int   fr;
      out_t o;
      byp = (k == 1);
      if (!rn) begin
        for (int i = 0; i < NP; i++) m_rd[k][i] = -1;
        m_err[k] = 1'b0;
      end
      full = 1'b1;
      fr   = -1;
      for (int i = 0; i < NP; i++) begin
        if (m_rd[k][i] < 0) begin
          full = 1'b0;
          if (fr < 0) fr = i;
        end
      end
      raw = (u1 && rs1 != 0 && pend(k, rs1, byp, cv, ct)) ||
            (u2 && rs2 != 0 && pend(k, rs2, byp, cv, ct));
      waw = lo && rd != 0 && pend(k, rd, byp, cv, ct);
      st  = lo && rd != 0 && full;
      hz  = raw || waw || st;
      o      = '0;
      o.full = full;
      o.err  = m_err[k];
      if (fb) begin
        o.fif = 1'b1;
        o.fid = 1'b1;
      end else if (hz) begin
        o.spc = 1'b1;
        o.sif = 1'b1;
        o.fid = 1'b1;
      end else begin
        o.issue = lo && rd != 0;
      end
      o.tag       = full ? '0 : TW'(fr);
      e.tagchk[k] = !full;
      e.o[k]      = o;
      if (rn) begin
        if (cv) begin
          if (m_rd[k][ct] < 0) m_err[k] = 1'b1;
          else m_rd[k][ct] = -1;
        end
        if (o.issue) m_rd[k][fr] = rd;
      end
    end
    q.push_back(e);
  endtask

  task automatic idle(bit rn);
    drive(rn, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor
  initial begin
    exp_t e;
    out_t a, x;
    stall_ph[0] = 0;
    stall_ph[1] = 0;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        for (int k = 0; k < 2; k++) begin
          if (k == 0)
            a = {b0.issue, b0.alloc_tag, b0.stall_pc,
                 b0.stall_IF, b0.flush_IF, b0.flush_ID,
                 b0.sb_full, b0.sb_err};
          else
            a = {b1.issue, b1.alloc_tag, b1.stall_pc,
                 b1.stall_IF, b1.flush_IF, b1.flush_ID,
                 b1.sb_full, b1.sb_err};
          x = e.o[k];
          if (!e.tagchk[k]) begin
            a.tag = '0;
            x.tag = '0;
          end
          if (e.phase == 1 && a.spc) stall_ph[k]++;
          checks++;
          if (a !== x) begin
            failures++;
            $display("FAIL outputs bypass=%0d phase=%0d t=%0t got=%b required=%b",
                     k, e.phase, $time, a, x);
          end
        end
      end
    end
  end

  initial begin
    int r1, r2, rd, ct, v;
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < NP; i++) m_rd[k][i] = -1;
      m_err[k] = 1'b0;
    end
    b0.rs1_addr_ID = '0; b1.rs1_addr_ID = '0;
    b0.rs2_addr_ID = '0; b1.rs2_addr_ID = '0;
    b0.rs1_used_ID = 0;  b1.rs1_used_ID = 0;
    b0.rs2_used_ID = 0;  b1.rs2_used_ID = 0;
    b0.rd_addr_ID  = '0; b1.rd_addr_ID  = '0;
    b0.long_op_ID  = 0;  b1.long_op_ID  = 0;
    b0.flush_br    = 0;  b1.flush_br    = 0;
    b0.cmpl_valid  = 0;  b1.cmpl_valid  = 0;
    b0.cmpl_tag    = '0; b1.cmpl_tag    = '0;

    idle(0);
    idle(0);
    idle(1);

    // lw x5; add x6,x5,x1; completion 3 cycles after issue
    drive(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0);
    drive(1, 5, 1, 1, 1, 6, 0, 0, 0, 0, 1);
    drive(1, 5, 1, 1, 1, 6, 0, 0, 0, 0, 1);
    drive(1, 5, 1, 1, 1, 6, 0, 0, 1, 0, 1);
    drive(1, 5, 1, 1, 1, 6, 0, 0, 0, 0, 1);

    // fill x1..x4, fifth long op to x7, free tag 2
    idle(0);
    for (int r = 1; r <= 4; r++)
      drive(1, 0, 0, 0, 0, r, 1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 7, 1, 0, 1, 2, 0);
    drive(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0);

    // RAW on x5 with branch flush, then next long op
    idle(0);
    drive(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0);
    drive(1, 5, 1, 0, 0, 9, 1, 1, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 9, 1, 0, 0, 0, 0);

    // rd=x0 long op; add x1,x0,x0
    drive(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    drive(1, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0);

    // WAW on x8
    idle(0);
    drive(1, 0, 0, 0, 0, 8, 1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 8, 1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 8, 1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 8, 1, 0, 1, 0, 0);
    drive(1, 0, 0, 0, 0, 8, 1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 8, 1, 0, 1, 1, 0);
    drive(1, 0, 0, 0, 0, 8, 1, 0, 0, 0, 0);

    // invalid completion, then reset mid-stall
    idle(0);
    drive(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 3, 0);
    drive(1, 5, 1, 0, 0, 6, 0, 0, 0, 0, 0);
    drive(1, 5, 1, 0, 0, 6, 0, 0, 0, 0, 0);
    drive(0, 5, 1, 0, 0, 6, 0, 0, 0, 0, 0);
    drive(1, 5, 1, 0, 0, 6, 0, 0, 0, 0, 0);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      r1 = $urandom_range(0, 7);
      r2 = $urandom_range(0, 7);
      rd = $urandom_range(0, 7);
      ct = $urandom_range(0, NP - 1);
      if ($urandom_range(0, 9) < 8) begin
        for (int t = 0; t < NP; t++) begin
          v = (ct + t) % NP;
          if (m_rd[1][v] >= 0) begin
            ct = v;
            break;
          end
        end
      end
      drive($urandom_range(0, 59) != 0,
            r1, 1'($urandom_range(0, 1)),
            r2, 1'($urandom_range(0, 1)),
            rd, $urandom_range(0, 9) < 4,
            $urandom_range(0, 9) == 0,
            $urandom_range(0, 9) < 4,
            ct, 0);
    end

    for (int i = 0; i < 20 && q.size() > 0; i++)
      @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d left, required 0", q.size());
    end

    checks++;
    if (stall_ph[1] != 2) begin
      failures++;
      $display("FAIL stall_len_bypass1: got %0d required 2",
               stall_ph[1]);
    end
    checks++;
    if (stall_ph[0] != 3) begin
      failures++;
      $display("FAIL stall_len_bypass0: got %0d required 3",
               stall_ph[0]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
